sync_delay_search_ctrl: RTL and testbench

- Controller that sequences the receive-path sample-delay configuration to find the optimal sampling phase.
- Steps a candidate delay select over all settings and waits for the path to settle. Captures the accumulated squared error (acc_err_sq) at the end of an LFSR measurement window, then locks the delay with minimum error.
- Sits between the LFSR cycle markers / rx performance modules and the delay select input of the sync modules.

---
 rtl/sync_delay_search_ctrl_pkg.sv | 14 +
 rtl/sync_delay_search_ctrl_sym_counter.sv | 29 ++
 rtl/sync_delay_search_ctrl.sv | 156 +++++++++++++++
 tb/tb_sync_delay_search_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_delay_search_ctrl_pkg.sv
// Shared types and constants for the receive sample-delay search controller.
package sync_delay_search_ctrl_pkg;
  localparam int ERR_W = 18;
  localparam logic signed [ERR_W-1:0] ERR_MAX = 18'sh1FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ARM,
    S_MEASURE,
    S_COMPARE,
    S_LOCKED
  } state_t;
endpackage

// File: rtl/sync_delay_search_ctrl_sym_counter.sv
// Symbol-enable counter with synchronous clear; tc flags the TERM-th qualified pulse.
module sync_delay_search_ctrl_sym_counter #(
  parameter int TERM = 32
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CNT_W = (TERM > 1) ? $clog2(TERM) : 1;

  logic [CNT_W-1:0] cnt;
  logic             at_term;

  assign at_term = (cnt == CNT_W'(TERM - 1));
  assign tc      = en && at_term;

  // Holds at the terminal value so a late-served tc can fire again on the next pulse.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_term) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sync_delay_search_ctrl.sv
// Sweeps delay_sel over all candidates, measures windowed squared error, locks the minimum.
// Optional `DELAY_RETRACK_EN: restart the search from LOCKED when the error degrades.
module sync_delay_search_ctrl
  import sync_delay_search_ctrl_pkg::*;
#(
  parameter int NUM_DELAYS   = 16,
  parameter int DLY_W        = 4,
  parameter int SETTLE_SYMS  = 32,
  parameter int TIMEOUT_SYMS = 4096
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    sym_clk_en,
  input  logic                    start,
  input  logic                    cycle_periodic,
  input  logic signed [ERR_W-1:0] acc_err_sq,
  output logic [DLY_W-1:0]        delay_sel,
  output logic [DLY_W-1:0]        best_delay,
  output logic signed [ERR_W-1:0] best_err,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout
);

  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [ERR_W-1:0] e);
    return e[ERR_W-1] ? ERR_MAX : e;
  endfunction

  state_t                  state;
  logic                    settle_clr, settle_en, settle_tc;
  logic                    to_clr, to_en, to_tc;
  logic                    meas_win, to_expire, cap_load;
  logic signed [ERR_W-1:0] cap_err, cap_val;
  logic                    better, last_cand, retrack;

  assign settle_en  = sym_clk_en && (state == S_SETTLE);
  assign settle_clr = (state != S_SETTLE);
  assign to_en      = sym_clk_en && ((state == S_ARM) || (state == S_MEASURE));
  assign to_clr     = !((state == S_ARM) || (state == S_MEASURE));

  sync_delay_search_ctrl_sym_counter #(.TERM(SETTLE_SYMS)) u_settle_cnt (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clr     (settle_clr),
    .en      (settle_en),
    .tc      (settle_tc)
  );

  sync_delay_search_ctrl_sym_counter #(.TERM(TIMEOUT_SYMS)) u_timeout_cnt (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clr     (to_clr),
    .en      (to_en),
    .tc      (to_tc)
  );

  // A window end always beats a coincident timeout terminal count.
  assign meas_win  = (state == S_MEASURE) && cycle_periodic;
  assign to_expire = !to_clr && to_tc && !cycle_periodic;
  assign cap_load  = meas_win || to_expire;
  assign cap_val   = meas_win ? sat_err(acc_err_sq) : ERR_MAX;

  // Capture stage: data register, loaded only when a measurement completes.
  always_ff @(posedge sys_clk) begin
    if (cap_load) begin
      cap_err <= cap_val;
    end
  end

  assign better    = (cap_err < best_err);
  assign last_cand = (delay_sel == DLY_W'(NUM_DELAYS - 1));

`ifdef DELAY_RETRACK_EN
  function automatic logic signed [ERR_W-1:0] dbl_sat(input logic signed [ERR_W-1:0] e);
    return (e[ERR_W-1:ERR_W-2] != 2'b00) ? ERR_MAX : {e[ERR_W-2:0], 1'b0};
  endfunction

  logic win_par;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      win_par <= 1'b0;
    end else if (state != S_LOCKED) begin
      win_par <= 1'b0;
    end else if (cycle_periodic) begin
      win_par <= ~win_par;
    end
  end

  assign retrack = (state == S_LOCKED) && cycle_periodic && win_par &&
                   (sat_err(acc_err_sq) > dbl_sat(best_err));
`else
  assign retrack = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      delay_sel  <= '0;
      best_delay <= '0;
      best_err   <= ERR_MAX;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_LOCKED: begin
          if (start || retrack) begin
            state      <= S_SETTLE;
            delay_sel  <= '0;
            best_delay <= '0;
            best_err   <= ERR_MAX;
            timeout    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_tc) state <= S_ARM;
        end
        S_ARM: begin
          if (cycle_periodic) begin
            state <= S_MEASURE;
          end else if (to_tc) begin
            timeout <= 1'b1;
            state   <= S_COMPARE;
          end
        end
        S_MEASURE: begin
          if (cycle_periodic) begin
            state <= S_COMPARE;
          end else if (to_tc) begin
            timeout <= 1'b1;
            state   <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (better) begin
            best_err   <= cap_err;
            best_delay <= delay_sel;
          end
          if (last_cand) begin
            state     <= S_LOCKED;
            delay_sel <= better ? delay_sel : best_delay;
            done      <= 1'b1;
            busy      <= 1'b0;
          end else begin
            delay_sel <= delay_sel + 1'b1;
            state     <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sync_delay_search_ctrl.sv
// Scoreboard bench for sync_delay_search_ctrl (4 delays, 8-symbol settle, 64-symbol timeout).
module tb_sync_delay_search_ctrl;
  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_clk_en = 1'b0;
  logic        start = 1'b0;
  logic        cycle_periodic = 1'b0;
  logic [17:0] acc_err_sq = '0;
  logic [1:0]  delay_sel, best_delay;
  logic [17:0] best_err;
  logic        busy, done, timeout;

  typedef struct {
    logic [1:0]  bd;
    logic [17:0] be;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  sync_delay_search_ctrl #(
    .NUM_DELAYS(4), .DLY_W(2), .SETTLE_SYMS(8), .TIMEOUT_SYMS(64)
  ) dut (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .sym_clk_en     (sym_clk_en),
    .start          (start),
    .cycle_periodic (cycle_periodic),
    .acc_err_sq     (acc_err_sq),
    .delay_sel      (delay_sel),
    .best_delay     (best_delay),
    .best_err       (best_err),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    forever begin
      @(negedge sys_clk);
      sym_clk_en = ~sym_clk_en;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_cp(input logic [17:0] v);
    cycle_periodic = 1'b1;
    acc_err_sq     = v;
    step(1);
    cycle_periodic = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_sel(input int k);
    int w = 0;
    while (32'(delay_sel) != k && w < 400) begin
      step(1);
      w++;
    end
    check("sel_step", 32'(delay_sel), 32'(k));
  endtask

  // Completion monitor: pops the expected result on each done pulse.
  initial begin
    logic prev_done = 1'b0;
    exp_t x;
    forever begin
      @(negedge sys_clk);
      if (prev_done) check("done_one_cycle", 32'(done), 32'(0));
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'(done), 32'(0));
        end else begin
          x = sb.pop_front();
          check("best_delay", 32'(best_delay), 32'(x.bd));
          check("best_err", 32'(best_err), 32'(x.be));
          check("timeout", 32'(timeout), 32'(x.to));
          check("locked_sel", 32'(delay_sel), 32'(x.bd));
          check("busy_at_done", 32'(busy), 32'(0));
        end
      end
      prev_done = done;
    end
  end

  // errs < 0 means the candidate gets no window at all (timeout).
  task automatic run_search(input int e0, input int e1, input int e2, input int e3,
                            input bit do_start, input int start_k);
    int   errs[4];
    int   best, bd, v, w;
    bit   to;
    exp_t x;
    errs = '{e0, e1, e2, e3};
    best = 'h1FFFF;
    bd   = 0;
    to   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (errs[k] < 0) begin
        v  = 'h1FFFF;
        to = 1'b1;
      end else if ((errs[k] & 'h20000) != 0) begin
        v = 'h1FFFF;
      end else begin
        v = errs[k];
      end
      if (v < best) begin
        best = v;
        bd   = k;
      end
    end
    x.bd = 2'(bd);
    x.be = 18'(best);
    x.to = to;
    sb.push_back(x);

    if (do_start) pulse_start();
    check("start_busy", 32'(busy), 32'(1));
    check("start_err", 32'(best_err), 32'h1FFFF);
    check("start_sel", 32'(delay_sel), 32'(0));
    check("start_to", 32'(timeout), 32'(0));

    for (int k = 0; k < 4; k++) begin
      if (k > 0) wait_sel(k);
      step(24);
      if (errs[k] >= 0) begin
        pulse_cp(18'd5);
        step(2);
        if (k == start_k) begin
          pulse_start();
          check("start_ignored", 32'(delay_sel), 32'(k));
        end
        step(2);
        pulse_cp(18'(errs[k]));
      end
    end
    w = 0;
    while (busy && w < 400) begin
      step(1);
      w++;
    end
    check("lock_busy", 32'(busy), 32'(0));
    check("lock_sel", 32'(delay_sel), 32'(bd));
  endtask

  initial begin
    step(2);
    check("rst_sel", 32'(delay_sel), 32'(0));
    check("rst_bdly", 32'(best_delay), 32'(0));
    check("rst_err", 32'(best_err), 32'h1FFFF);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_to", 32'(timeout), 32'(0));
    reset = 1'b0;
    step(2);

    // Asynchronous reset while settling on candidate 2.
    pulse_start();
    step(24);
    pulse_cp(18'd5);
    step(4);
    pulse_cp(18'd50);
    wait_sel(1);
    step(24);
    pulse_cp(18'd5);
    step(4);
    pulse_cp(18'd60);
    wait_sel(2);
    step(5);
    check("pre_rst_err", 32'(best_err), 32'd50);
    check("pre_rst_busy", 32'(busy), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_sel", 32'(delay_sel), 32'(0));
    check("arst_err", 32'(best_err), 32'h1FFFF);
    check("arst_bdly", 32'(best_delay), 32'(0));
    check("arst_to", 32'(timeout), 32'(0));
    step(1);
    reset = 1'b0;
    step(2);

    run_search(500, 120, 300, 120, 1'b1, -1);
    run_search(200, 90, -1, 150, 1'b1, -1);
    run_search('h20005, 'h20005, 'h20005, 'h20005, 1'b1, -1);
    run_search(40, 30, 20, 10, 1'b1, 1);
    run_search(300, 100, 300, 300, 1'b1, -1);

`ifdef DELAY_RETRACK_EN
    step(3);
    pulse_cp(18'd180);
    step(3);
    pulse_cp(18'd180);
    step(2);
    check("retrack_hold_busy", 32'(busy), 32'(0));
    check("retrack_hold_sel", 32'(delay_sel), 32'(1));
    pulse_cp(18'd250);
    step(3);
    check("retrack_skip_busy", 32'(busy), 32'(0));
    pulse_cp(18'd250);
    run_search(60, 70, 80, 90, 1'b0, -1);
`else
    for (int i = 0; i < 4; i++) begin
      step(3);
      pulse_cp(18'h1FFF0);
    end
    step(2);
    check("locked_hold_busy", 32'(busy), 32'(0));
    check("locked_hold_sel", 32'(delay_sel), 32'(1));
`endif

    step(4);
    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
